// File: rtl/sig_gen_pkg.sv
// Shared definitions for the sine generator: FSM encoding, default ROM geometry
// and the channel-2 address helper used by the phase accumulator.
package sig_gen_pkg;

  localparam int DEFAULT_ADDRESS_WIDTH = 8;
  localparam int DEFAULT_FRAC_WIDTH    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Caller truncates to the ROM address width, which gives the modulo wrap.
  function automatic logic [31:0] channel2_addr(input logic [31:0] acc_top,
                                                input logic [31:0] offset);
    return acc_top + offset;
  endfunction

endpackage

// File: rtl/phase_addr_gen.sv
// Phase-accumulator address generator for the dual-port sine ROM. Step and offset
// updates are double-buffered and only take effect at a waveform wrap (or in IDLE).
module phase_addr_gen
  import sig_gen_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int FRAC_WIDTH    = DEFAULT_FRAC_WIDTH,
  parameter int RESET_STEP    = 2**FRAC_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            stop,
  input  logic [ADDRESS_WIDTH+FRAC_WIDTH-1:0] step_in,
  input  logic [ADDRESS_WIDTH-1:0]        offset_in,
  input  logic                            load,
  output logic                            load_ack,
  output logic [ADDRESS_WIDTH-1:0]        addr1,
  output logic [ADDRESS_WIDTH-1:0]        addr2,
  output logic                            active,
  output logic                            wrap
);

  localparam int ACC_WIDTH = ADDRESS_WIDTH + FRAC_WIDTH;

  state_t                   state_reg, state_next;
  logic [ACC_WIDTH-1:0]     acc_reg, acc_next;
  logic [ACC_WIDTH-1:0]     step_act_reg, step_act_next;
  logic [ADDRESS_WIDTH-1:0] offset_act_reg, offset_act_next;
  logic [ACC_WIDTH-1:0]     shadow_step_reg;
  logic [ADDRESS_WIDTH-1:0] shadow_offset_reg;
  logic                     pending_reg;
  logic [ADDRESS_WIDTH-1:0] addr2_reg, addr2_next;
  logic                     wrap_reg, wrap_next;
  logic                     load_ack_reg;
  logic                     active_reg;
  logic [ACC_WIDTH:0]       sum;
  logic                     carry;
  logic                     apply;

  assign sum   = {1'b0, acc_reg} + {1'b0, step_act_reg};
  assign carry = sum[ACC_WIDTH];

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    wrap_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        acc_next = '0;
        if (start && !stop) state_next = RUN;
      end
      RUN: begin
        acc_next  = sum[ACC_WIDTH-1:0];
        wrap_next = carry;
        if (stop) state_next = DRAIN;
      end
      DRAIN: begin
        wrap_next = carry;
        // A fresh start cancels the drain before the end-of-cycle check.
        if (start && !stop) begin
          state_next = RUN;
          acc_next   = sum[ACC_WIDTH-1:0];
        end else if (carry || step_act_reg == '0) begin
          state_next = IDLE;
          acc_next   = '0;
        end else begin
          acc_next = sum[ACC_WIDTH-1:0];
        end
      end
      default: begin
        state_next = IDLE;
        acc_next   = '0;
      end
    endcase
  end

  // pending_reg is registered, so a load on the wrap edge itself waits a full cycle.
  assign apply           = pending_reg && ((state_reg == IDLE) || wrap_next);
  assign step_act_next   = apply ? shadow_step_reg   : step_act_reg;
  assign offset_act_next = apply ? shadow_offset_reg : offset_act_reg;
  assign addr2_next      = ADDRESS_WIDTH'(channel2_addr(32'(acc_next[ACC_WIDTH-1:FRAC_WIDTH]),
                                                        32'(offset_act_next)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= IDLE;
      acc_reg           <= '0;
      step_act_reg      <= ACC_WIDTH'(RESET_STEP);
      offset_act_reg    <= '0;
      shadow_step_reg   <= '0;
      shadow_offset_reg <= '0;
      pending_reg       <= 1'b0;
      addr2_reg         <= '0;
      wrap_reg          <= 1'b0;
      load_ack_reg      <= 1'b0;
      active_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      acc_reg        <= acc_next;
      step_act_reg   <= step_act_next;
      offset_act_reg <= offset_act_next;
      addr2_reg      <= addr2_next;
      wrap_reg       <= wrap_next;
      load_ack_reg   <= apply;
      active_reg     <= (state_next != IDLE);
      if (load) begin
        shadow_step_reg   <= step_in;
        shadow_offset_reg <= offset_in;
        pending_reg       <= 1'b1;
      end else if (apply) begin
        pending_reg <= 1'b0;
      end
    end
  end

  assign addr1    = acc_reg[ACC_WIDTH-1:FRAC_WIDTH];
  assign addr2    = addr2_reg;
  assign wrap     = wrap_reg;
  assign load_ack = load_ack_reg;
  assign active   = active_reg;

endmodule

// File: tb/tb_phase_addr_gen.sv
// Directed bench for phase_addr_gen: run/wrap, drain and cancel, double-buffered
// step/offset loads in IDLE and RUN, and asynchronous reset mid-run.
module tb_phase_addr_gen;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [15:0] step_in;
  logic [7:0]  offset_in;
  logic        load;
  logic        load_ack;
  logic [7:0]  addr1;
  logic [7:0]  addr2;
  logic        active;
  logic        wrap;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  phase_addr_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .step_in   (step_in),
    .offset_in (offset_in),
    .load      (load),
    .load_ack  (load_ack),
    .addr1     (addr1),
    .addr2     (addr2),
    .active    (active),
    .wrap      (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; load = 1'b0;
    step_in = '0; offset_in = '0;
    tick();
    chk("rst_addr1", 32'(addr1), 32'h0);
    chk("rst_addr2", 32'(addr2), 32'h0);
    chk("rst_active", 32'(active), 32'h0);
    chk("rst_wrap", 32'(wrap), 32'h0);
    chk("rst_load_ack", 32'(load_ack), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_addr1", 32'(addr1), 32'h0);

    // Default step: one address per clock, wrap 256 cycles after start.
    start = 1'b1; tick(); start = 1'b0;
    chk("start_active", 32'(active), 32'h1);
    chk("start_addr1", 32'(addr1), 32'h0);
    for (int i = 1; i < 256; i++) begin
      tick();
      chk("run_addr1", 32'(addr1), 32'(i));
      chk("run_addr2", 32'(addr2), 32'(i));
      chk("run_wrap", 32'(wrap), 32'h0);
    end
    tick();
    chk("wrap1_pulse", 32'(wrap), 32'h1);
    chk("wrap1_addr1", 32'(addr1), 32'h0);
    tick();
    chk("wrap1_clear", 32'(wrap), 32'h0);
    chk("wrap1_next", 32'(addr1), 32'h1);

    // Stop at 0x10: drain to end of cycle, then park at 0.
    run(15);
    chk("pre_stop_addr1", 32'(addr1), 32'h10);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("drain_addr1", 32'(addr1), 32'h11);
    chk("drain_active", 32'(active), 32'h1);
    run(238);
    chk("drain_end_addr1", 32'(addr1), 32'hFF);
    chk("drain_end_active", 32'(active), 32'h1);
    chk("drain_end_wrap", 32'(wrap), 32'h0);
    tick();
    chk("drain_wrap", 32'(wrap), 32'h1);
    chk("drain_idle_active", 32'(active), 32'h0);
    chk("drain_idle_addr1", 32'(addr1), 32'h0);
    tick();
    chk("idle_hold_addr1", 32'(addr1), 32'h0);
    chk("idle_hold_active", 32'(active), 32'h0);
    chk("idle_hold_wrap", 32'(wrap), 32'h0);

    // Start during DRAIN at 0x50 resumes without a stall.
    start = 1'b1; tick(); start = 1'b0;
    run(16);
    stop = 1'b1; tick(); stop = 1'b0;
    run(63);
    chk("cancel_at_addr1", 32'(addr1), 32'h50);
    start = 1'b1; tick(); start = 1'b0;
    chk("cancel_addr1", 32'(addr1), 32'h51);
    chk("cancel_active", 32'(active), 32'h1);
    run(174);
    chk("cancel_ff", 32'(addr1), 32'hFF);
    tick();
    chk("cancel_wrap", 32'(wrap), 32'h1);
    chk("cancel_still_active", 32'(active), 32'h1);
    chk("cancel_wrap_addr1", 32'(addr1), 32'h0);

    // Step 0x0200 loaded at addr1=0x80 takes effect only at the wrap.
    run(128);
    chk("ld_run_at", 32'(addr1), 32'h80);
    step_in = 16'h0200; offset_in = 8'h00; load = 1'b1; tick(); load = 1'b0;
    chk("ld_run_addr1", 32'(addr1), 32'h81);
    chk("ld_run_noack", 32'(load_ack), 32'h0);
    run(126);
    chk("ld_run_ff", 32'(addr1), 32'hFF);
    chk("ld_run_ff_noack", 32'(load_ack), 32'h0);
    tick();
    chk("ld_run_wrap", 32'(wrap), 32'h1);
    chk("ld_run_ack", 32'(load_ack), 32'h1);
    chk("ld_run_wrap_addr1", 32'(addr1), 32'h0);
    tick();
    chk("ld_run_step2a", 32'(addr1), 32'h2);
    chk("ld_run_ack_clear", 32'(load_ack), 32'h0);
    tick();
    chk("ld_run_step2b", 32'(addr1), 32'h4);

    // Drain back to IDLE at step 2.
    stop = 1'b1; tick(); stop = 1'b0;
    run(124);
    chk("drain2_fe", 32'(addr1), 32'hFE);
    chk("drain2_active", 32'(active), 32'h1);
    tick();
    chk("drain2_wrap", 32'(wrap), 32'h1);
    chk("drain2_idle", 32'(active), 32'h0);
    chk("drain2_addr1", 32'(addr1), 32'h0);

    // IDLE load: half step plus offset 0x40.
    step_in = 16'h0080; offset_in = 8'h40; load = 1'b1; tick(); load = 1'b0;
    chk("ld_idle_noack", 32'(load_ack), 32'h0);
    chk("ld_idle_addr2_old", 32'(addr2), 32'h0);
    tick();
    chk("ld_idle_ack", 32'(load_ack), 32'h1);
    chk("ld_idle_addr2", 32'(addr2), 32'h40);
    chk("ld_idle_addr1", 32'(addr1), 32'h0);
    tick();
    chk("ld_idle_ack_clear", 32'(load_ack), 32'h0);
    start = 1'b1; tick(); start = 1'b0;
    chk("half_addr1_0", 32'(addr1), 32'h0);
    chk("half_addr2_0", 32'(addr2), 32'h40);
    tick();
    chk("half_addr1_hold", 32'(addr1), 32'h0);
    tick();
    chk("half_addr1_1", 32'(addr1), 32'h1);
    chk("half_addr2_1", 32'(addr2), 32'h41);
    run(478);
    chk("off_addr1_f0", 32'(addr1), 32'hF0);
    chk("off_addr2_30", 32'(addr2), 32'h30);
    run(31);
    chk("half_addr1_ff", 32'(addr1), 32'hFF);
    chk("half_nowrap", 32'(wrap), 32'h0);
    tick();
    chk("half_wrap512", 32'(wrap), 32'h1);
    chk("half_wrap_addr1", 32'(addr1), 32'h0);
    chk("half_wrap_addr2", 32'(addr2), 32'h40);

    // Load step 0x0300, reach addr1=0x7A, then async reset.
    step_in = 16'h0300; offset_in = 8'h40; load = 1'b1; tick(); load = 1'b0;
    run(510);
    chk("ld3_nowrap", 32'(wrap), 32'h0);
    chk("ld3_noack", 32'(load_ack), 32'h0);
    tick();
    chk("ld3_wrap", 32'(wrap), 32'h1);
    chk("ld3_ack", 32'(load_ack), 32'h1);
    run(85);
    chk("ld3_ff", 32'(addr1), 32'hFF);
    tick();
    chk("ld3_wrap2", 32'(wrap), 32'h1);
    chk("ld3_remainder", 32'(addr1), 32'h02);
    chk("ld3_rem_addr2", 32'(addr2), 32'h42);
    run(40);
    chk("pre_rst_addr1", 32'(addr1), 32'h7A);
    chk("pre_rst_addr2", 32'(addr2), 32'hBA);
    chk("pre_rst_active", 32'(active), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_addr1", 32'(addr1), 32'h0);
    chk("arst_addr2", 32'(addr2), 32'h0);
    chk("arst_active", 32'(active), 32'h0);
    chk("arst_wrap", 32'(wrap), 32'h0);
    chk("arst_load_ack", 32'(load_ack), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_active", 32'(active), 32'h0);
    chk("post_rst_addr1", 32'(addr1), 32'h0);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    chk("post_rst_step_a1", 32'(addr1), 32'h1);
    chk("post_rst_step_a2", 32'(addr2), 32'h1);
    tick();
    chk("post_rst_step_b", 32'(addr1), 32'h2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
